// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter: response owner encoding,
// request bundle, and the word-legality check used by both the grant path and stats.
package dmem_arb_pkg;

    localparam int WORD_BYTES = 4;
    localparam int ALIGN_BITS = $clog2(WORD_BYTES);

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_M0   = 2'd1,
        OWNER_M1   = 2'd2
    } owner_e;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

    // A byte address is legal when it is word aligned and its word index is inside dmem.
    function automatic logic addr_legal(input logic [31:0] addr, input logic [31:0] depth);
        return (addr[ALIGN_BITS-1:0] == '0) && ((addr >> ALIGN_BITS) < depth);
    endfunction

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating count of consecutive cycles in which m1 asked but lost arbitration;
// force_m1 tells the grant logic that m1 has waited long enough and must win now.
module dmem_arb_starve_ctr #(
    parameter int MAX_WAIT = 4,
    parameter int WAIT_W   = $clog2(MAX_WAIT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic m1_valid,
    input  logic m1_grant,
    output logic force_m1
);

    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (!m1_valid || m1_grant) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    assign force_m1 = (wait_cnt == WAIT_MAX);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port data memory (m0 = CPU LSU, m1 = debug/DMA).
// Optional grant/error counters are built when DMEM_ARBITER_STATS_EN is defined.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DEPTH    = 64,
    parameter int MAX_WAIT = 4,
    parameter int WAIT_W   = $clog2(MAX_WAIT + 1)
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        m0_req_valid,
    input  logic        m0_req_we,
    input  logic [31:0] m0_req_addr,
    input  logic [31:0] m0_req_wdata,
    output logic        m0_req_ready,
    output logic        m0_rsp_valid,
    output logic [31:0] m0_rsp_rdata,
    output logic        m0_rsp_err,

    input  logic        m1_req_valid,
    input  logic        m1_req_we,
    input  logic [31:0] m1_req_addr,
    input  logic [31:0] m1_req_wdata,
    output logic        m1_req_ready,
    output logic        m1_rsp_valid,
    output logic [31:0] m1_rsp_rdata,
    output logic        m1_rsp_err,

    output logic [31:0] dmem_addr,
    input  logic [31:0] dmem_rdata,
    output logic        dmem_we,
    output logic [31:0] dmem_wdata
`ifdef DMEM_ARBITER_STATS_EN
    ,
    output logic [31:0] m0_grant_cnt,
    output logic [31:0] m1_grant_cnt,
    output logic [15:0] err_cnt
`endif
);

    // Handshake: a request transfers in the cycle where req_valid && req_ready; the
    // requester holds valid/we/addr/wdata stable until then. The response appears
    // exactly one cycle later as a single-cycle rsp_valid pulse with rdata/err.

    dmem_req_t req0;
    dmem_req_t req1;
    dmem_req_t sel;
    logic      force_m1;
    logic      grant0;
    logic      grant1;
    logic      granted;
    logic      sel_legal;

    owner_e      rsp_owner;
    logic [31:0] rdata_q;
    logic        err_q;

    assign req0 = '{valid: m0_req_valid, we: m0_req_we, addr: m0_req_addr, wdata: m0_req_wdata};
    assign req1 = '{valid: m1_req_valid, we: m1_req_we, addr: m1_req_addr, wdata: m1_req_wdata};

    dmem_arb_starve_ctr #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_starve_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .m1_valid (req1.valid),
        .m1_grant (grant1),
        .force_m1 (force_m1)
    );

    // Grant is deliberately not gated by reset so the memory path stays live.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req1.valid && force_m1) begin
            grant1 = 1'b1;
        end else if (req0.valid) begin
            grant0 = 1'b1;
        end else if (req1.valid) begin
            grant1 = 1'b1;
        end
    end

    always_comb begin
        sel = '0;
        if (grant0) begin
            sel = req0;
        end else if (grant1) begin
            sel = req1;
        end
    end

    assign granted   = sel.valid;
    assign sel_legal = addr_legal(sel.addr, 32'(DEPTH));

    assign m0_req_ready = grant0;
    assign m1_req_ready = grant1;

    assign dmem_addr  = sel.addr;
    assign dmem_wdata = sel.wdata;
    assign dmem_we    = granted && sel.we && sel_legal;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_owner <= OWNER_NONE;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            if (grant0) begin
                rsp_owner <= OWNER_M0;
            end else if (grant1) begin
                rsp_owner <= OWNER_M1;
            end else begin
                rsp_owner <= OWNER_NONE;
            end
            rdata_q <= (granted && sel_legal && !sel.we) ? dmem_rdata : '0;
            err_q   <= granted && !sel_legal;
        end
    end

    assign m0_rsp_valid = (rsp_owner == OWNER_M0);
    assign m1_rsp_valid = (rsp_owner == OWNER_M1);
    assign m0_rsp_rdata = rdata_q;
    assign m1_rsp_rdata = rdata_q;
    assign m0_rsp_err   = err_q;
    assign m1_rsp_err   = err_q;

`ifdef DMEM_ARBITER_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m0_grant_cnt <= '0;
            m1_grant_cnt <= '0;
            err_cnt      <= '0;
        end else begin
            if (grant0) begin
                m0_grant_cnt <= m0_grant_cnt + 32'd1;
            end
            if (grant1) begin
                m1_grant_cnt <= m1_grant_cnt + 32'd1;
            end
            if (granted && !sel_legal) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end
`endif

    a_grant_exclusive : assert property (@(posedge clk) !(grant0 && grant1));
    a_write_is_legal  : assert property (@(posedge clk) dmem_we |-> sel_legal);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic checked against
// a reference model of the arbitration rules and a shadow copy of memory.
module tb_dmem_arbiter;

    localparam int DEPTH    = 64;
    localparam int MAX_WAIT = 4;
    localparam int W        = 35;  // {owner[1:0], err, rdata[31:0]}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        m0_req_valid, m0_req_we, m0_req_ready, m0_rsp_valid, m0_rsp_err;
    logic [31:0] m0_req_addr, m0_req_wdata, m0_rsp_rdata;
    logic        m1_req_valid, m1_req_we, m1_req_ready, m1_rsp_valid, m1_rsp_err;
    logic [31:0] m1_req_addr, m1_req_wdata, m1_rsp_rdata;
    logic [31:0] dmem_addr, dmem_rdata, dmem_wdata;
    logic        dmem_we;
`ifdef DMEM_ARBITER_STATS_EN
    logic [31:0] m0_grant_cnt, m1_grant_cnt;
    logic [15:0] err_cnt;
`endif

    dmem_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .m0_req_valid (m0_req_valid),
        .m0_req_we    (m0_req_we),
        .m0_req_addr  (m0_req_addr),
        .m0_req_wdata (m0_req_wdata),
        .m0_req_ready (m0_req_ready),
        .m0_rsp_valid (m0_rsp_valid),
        .m0_rsp_rdata (m0_rsp_rdata),
        .m0_rsp_err   (m0_rsp_err),
        .m1_req_valid (m1_req_valid),
        .m1_req_we    (m1_req_we),
        .m1_req_addr  (m1_req_addr),
        .m1_req_wdata (m1_req_wdata),
        .m1_req_ready (m1_req_ready),
        .m1_rsp_valid (m1_rsp_valid),
        .m1_rsp_rdata (m1_rsp_rdata),
        .m1_rsp_err   (m1_rsp_err),
        .dmem_addr    (dmem_addr),
        .dmem_rdata   (dmem_rdata),
        .dmem_we      (dmem_we),
        .dmem_wdata   (dmem_wdata)
`ifdef DMEM_ARBITER_STATS_EN
        ,
        .m0_grant_cnt (m0_grant_cnt),
        .m1_grant_cnt (m1_grant_cnt),
        .err_cnt      (err_cnt)
`endif
    );

    // ---------------- memory attached to the DUT ----------------
    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE_0000 + 32'(i) * 32'h0000_0101;
    endfunction

    logic [31:0] mem [DEPTH];
    logic        preload;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
        end else if (dmem_we && (dmem_addr[31:2] < 30'(DEPTH))) begin
            mem[dmem_addr[7:2]] <= dmem_wdata;
        end
    end
    assign dmem_rdata = (dmem_addr[31:2] < 30'(DEPTH)) ? mem[dmem_addr[7:2]] : 32'hBAD0_BAD0;

    // ---------------- reference model / scoreboard ----------------
    logic [31:0]  shadow [DEPTH];
    int           m1_wait = 0;
    int           cnt_m0 = 0, cnt_m1 = 0, cnt_err = 0;
    logic [W-1:0] exp_q[$];
    int           checks = 0;
    int           errors = 0;

    function automatic logic is_legal(input logic [31:0] a);
        return ((a % 4) == 0) && ((a / 4) < DEPTH);
    endfunction

    // Returns 0 or 1 for the master that should win this cycle, -1 for none.
    function automatic int pick_grant();
        if (m1_req_valid && m1_wait >= MAX_WAIT) return 1;
        if (m0_req_valid) return 0;
        if (m1_req_valid) return 1;
        return -1;
    endfunction

    // Advance one clock and update the model with what the current inputs should do.
    task automatic cycle();
        int           g;
        logic [31:0]  a, wd, rd;
        logic         we, lg;
        logic [1:0]   own;
        logic [W-1:0] e;
        g = pick_grant();
        a = '0; wd = '0; rd = '0; we = 1'b0; lg = 1'b1; own = 2'd0;
        if (g == 0) begin
            a = m0_req_addr; wd = m0_req_wdata; we = m0_req_we; own = 2'd1;
        end else if (g == 1) begin
            a = m1_req_addr; wd = m1_req_wdata; we = m1_req_we; own = 2'd2;
        end
        if (g >= 0) lg = is_legal(a);
        if (g >= 0 && lg && !we) rd = shadow[a[7:2]];
        @(posedge clk);
        if (g >= 0 && lg && we) shadow[a[7:2]] = wd;
        if (!rst_n) begin
            e = '0;
            m1_wait = 0;
            cnt_m0 = 0; cnt_m1 = 0; cnt_err = 0;
        end else begin
            e = {own, (g >= 0) && !lg, rd};
            if (m1_req_valid && g != 1) m1_wait = (m1_wait < MAX_WAIT) ? m1_wait + 1 : MAX_WAIT;
            else m1_wait = 0;
            cnt_m0 += (g == 0) ? 1 : 0;
            cnt_m1 += (g == 1) ? 1 : 0;
            cnt_err += (g >= 0 && !lg) ? 1 : 0;
        end
        exp_q.push_back(e);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive0(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
        m0_req_valid = v; m0_req_we = we; m0_req_addr = a; m0_req_wdata = d;
    endtask

    task automatic drive1(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
        m1_req_valid = v; m1_req_we = we; m1_req_addr = a; m1_req_wdata = d;
    endtask

    task automatic idle();
        drive0(1'b0, 1'b0, 32'h0, 32'h0);
        drive1(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
        if (r == 1) return ($urandom() | 32'h0000_1000) & 32'hFFFF_FFFC;
        return 32'($urandom_range(0, 15)) * 4;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; preload = 1'b1; idle();
        cycle();
        preload = 1'b0;
        cycle();
        checks++; if (m0_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_m0_rsp_valid got=%b exp=0", m0_rsp_valid); end
        checks++; if (m1_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_m1_rsp_valid got=%b exp=0", m1_rsp_valid); end
        checks++; if (m0_rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", m0_rsp_rdata); end
        checks++; if (m0_rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", m0_rsp_err); end
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_raw();
        drive0(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
        #1;
        checks++; if (m0_req_ready !== 1'b1) begin errors++; $display("FAIL raw_m0_ready got=%b exp=1", m0_req_ready); end
        checks++; if (dmem_we !== 1'b1) begin errors++; $display("FAIL raw_dmem_we got=%b exp=1", dmem_we); end
        checks++; if (dmem_addr !== 32'h10) begin errors++; $display("FAIL raw_dmem_addr got=%h exp=10", dmem_addr); end
        checks++; if (dmem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL raw_dmem_wdata got=%h exp=deadbeef", dmem_wdata); end
        cycle();
        idle();
        drive1(1'b1, 1'b0, 32'h10, 32'h0);
        #1;
        checks++; if (m0_rsp_valid !== 1'b1) begin errors++; $display("FAIL raw_m0_rsp_valid got=%b exp=1", m0_rsp_valid); end
        checks++; if (m0_rsp_err !== 1'b0) begin errors++; $display("FAIL raw_m0_rsp_err got=%b exp=0", m0_rsp_err); end
        checks++; if (m1_req_ready !== 1'b1) begin errors++; $display("FAIL raw_m1_ready got=%b exp=1", m1_req_ready); end
        cycle();
        idle();
        checks++; if (m1_rsp_valid !== 1'b1) begin errors++; $display("FAIL raw_m1_rsp_valid got=%b exp=1", m1_rsp_valid); end
        checks++; if (m1_rsp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL raw_m1_rdata got=%h exp=deadbeef", m1_rsp_rdata); end
        checks++; if (m0_rsp_valid !== 1'b0) begin errors++; $display("FAIL raw_m0_rsp_quiet got=%b exp=0", m0_rsp_valid); end
        cycle();
    endtask

    task automatic test_fairness();
        logic         exp_m1;
        logic [W-1:0] e;
        idle();
        cycle();
        drive0(1'b1, 1'b0, 32'h20, 32'h0);
        drive1(1'b1, 1'b0, 32'h24, 32'h0);
        for (int i = 0; i < 10; i++) begin
            #1;
            exp_m1 = ((i % 5) == 4);
            checks++; if (m1_req_ready !== exp_m1) begin errors++; $display("FAIL fair_m1_ready i=%0d got=%b exp=%b", i, m1_req_ready, exp_m1); end
            checks++; if (m0_req_ready !== !exp_m1) begin errors++; $display("FAIL fair_m0_ready i=%0d got=%b exp=%b", i, m0_req_ready, !exp_m1); end
            cycle();
            e = exp_q[$];
            checks++; if (m0_rsp_rdata !== e[31:0]) begin errors++; $display("FAIL fair_rdata i=%0d got=%h exp=%h", i, m0_rsp_rdata, e[31:0]); end
        end
        idle();
        cycle();
    endtask

    task automatic test_misaligned();
        drive0(1'b1, 1'b1, 32'h12, 32'h1234_5678);
        #1;
        checks++; if (m0_req_ready !== 1'b1) begin errors++; $display("FAIL mis_m0_ready got=%b exp=1", m0_req_ready); end
        checks++; if (dmem_we !== 1'b0) begin errors++; $display("FAIL mis_dmem_we got=%b exp=0", dmem_we); end
        cycle();
        idle();
        checks++; if (m0_rsp_valid !== 1'b1) begin errors++; $display("FAIL mis_rsp_valid got=%b exp=1", m0_rsp_valid); end
        checks++; if (m0_rsp_err !== 1'b1) begin errors++; $display("FAIL mis_rsp_err got=%b exp=1", m0_rsp_err); end
        checks++; if (m0_rsp_rdata !== 32'h0) begin errors++; $display("FAIL mis_rsp_rdata got=%h exp=0", m0_rsp_rdata); end
        drive1(1'b1, 1'b0, 32'h10, 32'h0);
        cycle();
        idle();
        checks++; if (m1_rsp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mis_readback got=%h exp=deadbeef", m1_rsp_rdata); end
        checks++; if (m1_rsp_err !== 1'b0) begin errors++; $display("FAIL mis_readback_err got=%b exp=0", m1_rsp_err); end
        cycle();
    endtask

    task automatic test_out_of_range();
        drive1(1'b1, 1'b0, 32'h100, 32'h0);
        #1;
        checks++; if (m1_req_ready !== 1'b1) begin errors++; $display("FAIL oor_m1_ready got=%b exp=1", m1_req_ready); end
        checks++; if (dmem_we !== 1'b0) begin errors++; $display("FAIL oor_dmem_we got=%b exp=0", dmem_we); end
        cycle();
        idle();
        checks++; if (m1_rsp_valid !== 1'b1) begin errors++; $display("FAIL oor_rsp_valid got=%b exp=1", m1_rsp_valid); end
        checks++; if (m1_rsp_err !== 1'b1) begin errors++; $display("FAIL oor_rsp_err got=%b exp=1", m1_rsp_err); end
        checks++; if (m1_rsp_rdata !== 32'h0) begin errors++; $display("FAIL oor_rsp_rdata got=%h exp=0", m1_rsp_rdata); end
        checks++; if (m0_rsp_valid !== 1'b0) begin errors++; $display("FAIL oor_m0_quiet got=%b exp=0", m0_rsp_valid); end
        cycle();
    endtask

    task automatic test_reset_midstream();
        logic exp_m1;
        idle();
        cycle();
        drive0(1'b1, 1'b0, 32'h30, 32'h0);
        drive1(1'b1, 1'b0, 32'h34, 32'h0);
        repeat (3) cycle();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            checks++; if (m0_rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_m0_rsp i=%0d got=%b exp=0", i, m0_rsp_valid); end
            checks++; if (m1_rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_m1_rsp i=%0d got=%b exp=0", i, m1_rsp_valid); end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            exp_m1 = (i == 4);
            checks++; if (m1_req_ready !== exp_m1) begin errors++; $display("FAIL rstmid_m1_ready i=%0d got=%b exp=%b", i, m1_req_ready, exp_m1); end
            cycle();
            checks++; if (m0_rsp_valid !== !exp_m1) begin errors++; $display("FAIL rstmid_m0_rsp_valid i=%0d got=%b exp=%b", i, m0_rsp_valid, !exp_m1); end
            checks++; if (m1_rsp_valid !== exp_m1) begin errors++; $display("FAIL rstmid_m1_rsp_valid i=%0d got=%b exp=%b", i, m1_rsp_valid, exp_m1); end
        end
        idle();
        cycle();
    endtask

    task automatic test_random();
        logic         acc0, acc1, ewe;
        logic [31:0]  ea, ed;
        logic [W-1:0] e;
        int           g;
        int           m1_denied;
        acc0 = 1'b1; acc1 = 1'b1; m1_denied = 0;
        idle();
        cycle();
        for (int n = 0; n < 400; n++) begin
            if (!m0_req_valid || acc0)
                drive0(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), rand_addr(), $urandom());
            if (!m1_req_valid || acc1)
                drive1(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), rand_addr(), $urandom());
            #1;
            g = pick_grant();
            ea = '0; ed = '0; ewe = 1'b0;
            if (g == 0) begin
                ea = m0_req_addr; ed = m0_req_wdata; ewe = m0_req_we && is_legal(ea);
            end else if (g == 1) begin
                ea = m1_req_addr; ed = m1_req_wdata; ewe = m1_req_we && is_legal(ea);
            end
            checks++; if (m0_req_ready !== (g == 0)) begin errors++; $display("FAIL rnd_m0_ready n=%0d got=%b exp=%b", n, m0_req_ready, (g == 0)); end
            checks++; if (m1_req_ready !== (g == 1)) begin errors++; $display("FAIL rnd_m1_ready n=%0d got=%b exp=%b", n, m1_req_ready, (g == 1)); end
            checks++; if (dmem_we !== ewe) begin errors++; $display("FAIL rnd_dmem_we n=%0d got=%b exp=%b", n, dmem_we, ewe); end
            checks++; if (dmem_addr !== ea) begin errors++; $display("FAIL rnd_dmem_addr n=%0d got=%h exp=%h", n, dmem_addr, ea); end
            checks++; if (dmem_wdata !== ed) begin errors++; $display("FAIL rnd_dmem_wdata n=%0d got=%h exp=%h", n, dmem_wdata, ed); end
            if (m1_req_valid && !m1_req_ready) m1_denied++;
            else m1_denied = 0;
            checks++; if (m1_denied > MAX_WAIT) begin errors++; $display("FAIL rnd_m1_starved n=%0d got=%0d exp<=%0d", n, m1_denied, MAX_WAIT); end
            acc0 = (g == 0);
            acc1 = (g == 1);
            cycle();
            e = exp_q[$];
            checks++; if (m0_rsp_valid !== (e[34:33] == 2'd1)) begin errors++; $display("FAIL rnd_m0_rsp_valid n=%0d got=%b exp=%b", n, m0_rsp_valid, (e[34:33] == 2'd1)); end
            checks++; if (m1_rsp_valid !== (e[34:33] == 2'd2)) begin errors++; $display("FAIL rnd_m1_rsp_valid n=%0d got=%b exp=%b", n, m1_rsp_valid, (e[34:33] == 2'd2)); end
            checks++; if (m0_rsp_err !== e[32] || m1_rsp_err !== e[32]) begin errors++; $display("FAIL rnd_rsp_err n=%0d got=%b/%b exp=%b", n, m0_rsp_err, m1_rsp_err, e[32]); end
            checks++; if (m0_rsp_rdata !== e[31:0] || m1_rsp_rdata !== e[31:0]) begin errors++; $display("FAIL rnd_rsp_rdata n=%0d got=%h/%h exp=%h", n, m0_rsp_rdata, m1_rsp_rdata, e[31:0]); end
        end
        idle();
        cycle();
`ifdef DMEM_ARBITER_STATS_EN
        checks++; if (m0_grant_cnt !== 32'(cnt_m0)) begin errors++; $display("FAIL rnd_m0_grant_cnt got=%0d exp=%0d", m0_grant_cnt, cnt_m0); end
        checks++; if (m1_grant_cnt !== 32'(cnt_m1)) begin errors++; $display("FAIL rnd_m1_grant_cnt got=%0d exp=%0d", m1_grant_cnt, cnt_m1); end
        checks++; if (err_cnt !== 16'(cnt_err)) begin errors++; $display("FAIL rnd_err_cnt got=%0d exp=%0d", err_cnt, cnt_err); end
`endif
    endtask

`ifdef DMEM_ARBITER_STATS_EN
    task automatic test_stats();
        idle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        drive0(1'b1, 1'b1, 32'h40, 32'h0BAD_F00D); cycle(); idle();
        drive0(1'b1, 1'b0, 32'h40, 32'h0);         cycle(); idle();
        drive0(1'b1, 1'b0, 32'h44, 32'h0);         cycle(); idle();
        drive1(1'b1, 1'b0, 32'h48, 32'h0);         cycle(); idle();
        drive1(1'b1, 1'b0, 32'h200, 32'h0);        cycle(); idle();
        cycle();
        checks++; if (m0_grant_cnt !== 32'd3) begin errors++; $display("FAIL stats_m0_grant_cnt got=%0d exp=3", m0_grant_cnt); end
        checks++; if (m1_grant_cnt !== 32'd2) begin errors++; $display("FAIL stats_m1_grant_cnt got=%0d exp=2", m1_grant_cnt); end
        checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL stats_err_cnt got=%0d exp=1", err_cnt); end
    endtask
`endif

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    // ---------------- sequence and final report ----------------
    initial begin
        for (int i = 0; i < DEPTH; i++) shadow[i] = init_word(i);
        test_reset();
        test_raw();
        test_fairness();
        test_misaligned();
        test_out_of_range();
        test_reset_midstream();
        test_random();
`ifdef DMEM_ARBITER_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
